block_dev_arb: RTL



---
 rtl/block_dev_arb.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/block_dev_arb.sv
// Two-requester arbiter sharing a single block device, one command per grant.
// Define BD_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module block_dev_arb #(
    parameter int unsigned BSY_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [1:0]  rq0_cmd,
    input  logic [23:0] rq0_addr,
    input  logic        rq0_start,
    input  logic        rq0_rd,
    input  logic        rq0_wr,
    input  logic [15:0] rq0_data_in,
    output logic [15:0] rq0_data_out,
    output logic        rq0_bsy,
    output logic        rq0_err,
    output logic        rq0_iordy,
    output logic        rq0_rdy,

    input  logic [1:0]  rq1_cmd,
    input  logic [23:0] rq1_addr,
    input  logic        rq1_start,
    input  logic        rq1_rd,
    input  logic        rq1_wr,
    input  logic [15:0] rq1_data_in,
    output logic [15:0] rq1_data_out,
    output logic        rq1_bsy,
    output logic        rq1_err,
    output logic        rq1_iordy,
    output logic        rq1_rdy,

    output logic [1:0]  bd_cmd,
    output logic [23:0] bd_addr,
    output logic        bd_start,
    output logic        bd_rd,
    output logic        bd_wr,
    output logic [15:0] bd_data_in,
    input  logic [15:0] bd_data_out,
    input  logic        bd_bsy,
    input  logic        bd_err,
    input  logic        bd_iordy,
    input  logic        bd_rdy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAITBSY,
        XFER
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(BSY_WAIT - 1);

    state_t      state;
    state_t      state_nx;

    logic        pend0;
    logic        pend1;
    logic        err0;
    logic        err1;
    logic [1:0]  cmd0;
    logic [1:0]  cmd1;
    logic [23:0] addr0;
    logic [23:0] addr1;

    logic        gnt;        // 0 selects requester 0, 1 selects requester 1
    logic        win;
    logic        any_pend;
    logic        done;
    logic        gnt0;
    logic        gnt1;
    logic        pass;

    logic [7:0]  wcnt;
    logic        bd_start_q;
    logic [1:0]  bd_cmd_q;
    logic [23:0] bd_addr_q;

    assign any_pend = pend0 | pend1;
    assign gnt0     = (state != IDLE) & ~gnt;
    assign gnt1     = (state != IDLE) &  gnt;
    assign pass     = (state == START) | (state == WAITBSY) | (state == XFER);
    assign done     = ((state == WAITBSY) & ~bd_bsy & (wcnt == WAIT_LAST)) |
                      ((state == XFER) & ~bd_bsy);

`ifdef BD_ARB_RR_EN
    logic ptr;

    always_comb begin
        win = ~pend0;
        if (pend0 & pend1) begin
            win = ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~gnt;
        end
    end
`else
    // Requester 1 only wins when requester 0 has nothing pending.
    always_comb begin
        win = ~pend0;
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_pend) state_nx = SETUP;
            SETUP:   state_nx = START;
            START:   state_nx = WAITBSY;
            WAITBSY: begin
                if (bd_bsy) begin
                    state_nx = XFER;
                end else if (wcnt == WAIT_LAST) begin
                    state_nx = IDLE;
                end
            end
            XFER:    if (!bd_bsy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            bd_cmd_q   <= '0;
            bd_addr_q  <= '0;
            bd_start_q <= 1'b0;
            wcnt       <= '0;
        end else begin
            state      <= state_nx;
            bd_start_q <= (state == SETUP);
            // cmd/addr are loaded at grant so they are stable a full cycle before bd_start
            if ((state == IDLE) && any_pend) begin
                gnt       <= win;
                bd_cmd_q  <= win ? cmd1  : cmd0;
                bd_addr_q <= win ? addr1 : addr0;
            end
            if (state == START) begin
                wcnt <= '0;
            end else if ((state == WAITBSY) && !bd_bsy && (wcnt != WAIT_LAST)) begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend0 <= 1'b0;
            err0  <= 1'b0;
            cmd0  <= '0;
            addr0 <= '0;
        end else begin
            if ((state == START) && !gnt) begin
                pend0 <= 1'b0;
                err0  <= 1'b0;
            end else if ((state == XFER) && !gnt && bd_err) begin
                err0 <= 1'b1;
            end
            if (rq0_start && !pend0 && !gnt0) begin
                pend0 <= 1'b1;
                cmd0  <= rq0_cmd;
                addr0 <= rq0_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend1 <= 1'b0;
            err1  <= 1'b0;
            cmd1  <= '0;
            addr1 <= '0;
        end else begin
            if ((state == START) && gnt) begin
                pend1 <= 1'b0;
                err1  <= 1'b0;
            end else if ((state == XFER) && gnt && bd_err) begin
                err1 <= 1'b1;
            end
            if (rq1_start && !pend1 && !gnt1) begin
                pend1 <= 1'b1;
                cmd1  <= rq1_cmd;
                addr1 <= rq1_addr;
            end
        end
    end

    assign bd_cmd       = bd_cmd_q;
    assign bd_addr      = bd_addr_q;
    assign bd_start     = bd_start_q;
    assign bd_rd        = pass & (gnt ? rq1_rd : rq0_rd);
    assign bd_wr        = pass & (gnt ? rq1_wr : rq0_wr);
    assign bd_data_in   = pass ? (gnt ? rq1_data_in : rq0_data_in) : '0;

    assign rq0_data_out = bd_data_out;
    assign rq1_data_out = bd_data_out;
    assign rq0_bsy      = pend0 | gnt0;
    assign rq1_bsy      = pend1 | gnt1;
    assign rq0_err      = err0;
    assign rq1_err      = err1;
    assign rq0_iordy    = pass & ~gnt & bd_iordy;
    assign rq1_iordy    = pass &  gnt & bd_iordy;
    assign rq0_rdy      = pass & ~gnt & bd_rdy;
    assign rq1_rdy      = pass &  gnt & bd_rdy;

endmodule
